// File: rtl/e_mdu_pkg.sv
// Shared MD-unit definitions: op encodings, default latencies and op classifiers.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int MD_WIDTH_DEF       = 32;
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic md_is_long(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_class(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MFLO);
  endfunction

endpackage

// File: rtl/e_mdu_md_arith.sv
// Combinational mult/div datapath: maps (op, a, b) to {hi, lo} and a result-valid flag.
// Zero latency; res_valid drops for non-arith ops and for a zero divisor.
module e_mdu_md_arith
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_valid
);

  logic             is_signed;
  logic [2*WIDTH-1:0] a_x, b_x, prod;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);

  // Low 2W bits of the product of extended operands equal the signed/unsigned product.
  assign a_x  = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
  assign b_x  = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
  assign prod = a_x * b_x;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. -2^(W-1) magnitude is exact as unsigned.
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    res_valid = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        res_hi    = prod[2*WIDTH-1:WIDTH];
        res_lo    = prod[WIDTH-1:0];
        res_valid = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        if (b != '0) begin
          res_hi    = rem;
          res_lo    = quo;
          res_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; result commits MULT/DIV_CYCLES after accept.
// Accepts only when idle; md_stall tells the hazard unit to hold MD ops, flush cancels.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = MD_WIDTH_DEF,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       md_op,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] md_rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_valid_q, pend_valid_d;

  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_valid;

  e_mdu_md_arith #(.WIDTH(WIDTH)) u_md_arith (
    .op        (md_op),
    .a         (a),
    .b         (b),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Priority: flush, then countdown/commit, then a new accept (only when idle).
  always_comb begin
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    if (flush) begin
      busy_d       = 1'b0;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == CW'(1)) begin
        if (pend_valid_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        busy_d       = 1'b0;
        cnt_d        = '0;
        pend_valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          pend_hi_d    = res_hi;
          pend_lo_d    = res_lo;
          pend_valid_d = 1'b1;
          cnt_d        = CW'(MULT_CYCLES);
          busy_d       = 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          pend_hi_d    = res_hi;
          pend_lo_d    = res_lo;
          pend_valid_d = res_valid;
          cnt_d        = CW'(DIV_CYCLES);
          busy_d       = 1'b1;
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_comb begin
    md_rdata = '0;
    case (md_op)
      MD_MFHI: md_rdata = hi_q;
      MD_MFLO: md_rdata = lo_q;
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = (start & md_is_long(md_op)) | busy_q;

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(start && busy_q && md_is_class(md_op))
  );

endmodule
